// File: rtl/stream_fifo_clearable.sv
// Single-clock stream FIFO with a sequenced clear: isolate both ports, optionally
// drain to the consumer under a bounded timeout, then flush in one cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | normal streaming, clear_i sampled here only
// ISOLATE  | producer blocked for one cycle; consumer still served when draining
// DRAIN    | stored entries delivered to the consumer until empty or timeout
// FLUSH    | pointers and count cleared, clear_done_o pulses
module stream_fifo_clearable #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned DEPTH          = 4,
   parameter bit          DRAIN_ON_CLEAR = 1'b0,
   parameter int unsigned DRAIN_TIMEOUT  = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         clear_i,
   output logic                         clear_pending_o,
   output logic                         clear_done_o,
   output logic                         clear_dropped_o,
   input  logic [DATA_WIDTH-1:0]        src_data_i,
   input  logic                         src_valid_i,
   output logic                         src_ready_o,
   output logic [DATA_WIDTH-1:0]        dst_data_o,
   output logic                         dst_valid_o,
   input  logic                         dst_ready_i,
   output logic [$clog2(DEPTH+1)-1:0]   usage_o
);

   localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
   localparam int unsigned TMO_W    = (DRAIN_TIMEOUT > 0) ? $clog2(DRAIN_TIMEOUT + 1) : 1;
   localparam int unsigned TMO_LAST = (DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0;

   typedef enum logic [1:0] {S_IDLE, S_ISOLATE, S_DRAIN, S_FLUSH} state_t;

   state_t                 state_q;
   logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0]       rd_ptr_q;
   logic [PTR_W-1:0]       wr_ptr_q;
   logic [CNT_W-1:0]       count_q;
   logic [CNT_W-1:0]       count_nxt;
   logic [TMO_W-1:0]       tmo_cnt_q;
   logic                   full;
   logic                   empty;
   logic                   push;
   logic                   pop;
   logic                   tmo_hit;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   // No fall-through: a full FIFO refuses data even if it is popped this cycle.
   always_comb begin
      src_ready_o = 1'b0;
      dst_valid_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            src_ready_o = !full && !clear_i;
            dst_valid_o = !empty;
         end
         S_ISOLATE: dst_valid_o = DRAIN_ON_CLEAR && !empty;
         S_DRAIN:   dst_valid_o = !empty;
         default: ;
      endcase
   end

   assign push = src_valid_i && src_ready_o;
   assign pop  = dst_valid_o && dst_ready_i;

   always_comb begin
      count_nxt = count_q;
      if (push && !pop)
         count_nxt = count_q + CNT_W'(1);
      else if (pop && !push)
         count_nxt = count_q - CNT_W'(1);
   end

   assign tmo_hit = (DRAIN_TIMEOUT != 0) && (tmo_cnt_q == TMO_W'(TMO_LAST));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         tmo_cnt_q <= '0;
      end else begin
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_nxt;
         case (state_q)
            S_IDLE: if (clear_i) state_q <= S_ISOLATE;
            // Decide on the post-pop count so an entry taken here never strands DRAIN.
            S_ISOLATE: begin
               tmo_cnt_q <= '0;
               state_q   <= (DRAIN_ON_CLEAR && count_nxt != '0) ? S_DRAIN : S_FLUSH;
            end
            S_DRAIN: begin
               if (count_nxt == '0 || tmo_hit)
                  state_q <= S_FLUSH;
               else
                  tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end
            S_FLUSH: begin
               state_q  <= S_IDLE;
               rd_ptr_q <= '0;
               wr_ptr_q <= '0;
               count_q  <= '0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= src_data_i;
   end

   assign dst_data_o      = mem_q[rd_ptr_q];
   assign usage_o         = count_q;
   assign clear_pending_o = (state_q != S_IDLE);
   assign clear_done_o    = (state_q == S_FLUSH);
   assign clear_dropped_o = (state_q == S_FLUSH) && !empty;

   // Producer contract: never offer data in the same cycle as a clear request.
   a_no_valid_with_clear: assert property (@(posedge clk_i) disable iff (rst_i)
      !(src_valid_i && clear_i));

endmodule

// File: tb/tb_stream_fifo_clearable.sv
// Two FIFOs (discard-on-clear and drain-on-clear with timeout 4) share one stimulus
// stream; each is scored against a queue-based model of the clear sequence.
module tb_stream_fifo_clearable;

   localparam int DW    = 8;
   localparam int DEPTH = 3;
   localparam int TMO   = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clear = 1'b0;
   logic          src_valid = 1'b0;
   logic          dst_ready = 1'b0;
   logic [DW-1:0] src_data = '0;

   logic          pend  [2];
   logic          done  [2];
   logic          drop  [2];
   logic          srdy  [2];
   logic          dval  [2];
   logic [DW-1:0] ddata [2];
   logic [1:0]    usage [2];

   int            n_chk = 0;
   int            n_fail = 0;
   bit            mval = 1'b0;
   int            ph [2];
   int            tcnt [2];
   int            exp_done [2];
   int            act_done [2];
   logic [DW-1:0] mq [2][$];

   always #5 clk = ~clk;

   stream_fifo_clearable #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DRAIN_ON_CLEAR(1'b0),
                           .DRAIN_TIMEOUT(TMO)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .clear_i(clear),
      .clear_pending_o(pend[0]), .clear_done_o(done[0]), .clear_dropped_o(drop[0]),
      .src_data_i(src_data), .src_valid_i(src_valid), .src_ready_o(srdy[0]),
      .dst_data_o(ddata[0]), .dst_valid_o(dval[0]), .dst_ready_i(dst_ready),
      .usage_o(usage[0]));

   stream_fifo_clearable #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DRAIN_ON_CLEAR(1'b1),
                           .DRAIN_TIMEOUT(TMO)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .clear_i(clear),
      .clear_pending_o(pend[1]), .clear_done_o(done[1]), .clear_dropped_o(drop[1]),
      .src_data_i(src_data), .src_valid_i(src_valid), .src_ready_o(srdy[1]),
      .dst_data_o(ddata[1]), .dst_valid_o(dval[1]), .dst_ready_i(dst_ready),
      .usage_o(usage[1]));

   task automatic chk(input string name, input int i, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [dut%0d] at %0t: got %0h, expected %0h", name, i, $time, act, exp);
      end
   endtask

   // Monitor + reference model: inputs are stable from posedge+1 until the next posedge.
   task automatic model_cycle(input int i);
      int sz;
      bit drn, e_srdy, e_dval, do_push, do_pop;
      drn = (i == 1);
      sz  = mq[i].size();
      e_srdy = (ph[i] == 0) && (sz < DEPTH) && !clear;
      case (ph[i])
         0:       e_dval = (sz != 0);
         1:       e_dval = drn && (sz != 0);
         2:       e_dval = (sz != 0);
         default: e_dval = 1'b0;
      endcase
      if (mval) begin
         chk("src_ready", i, 32'(srdy[i]), 32'(e_srdy));
         chk("dst_valid", i, 32'(dval[i]), 32'(e_dval));
         chk("usage", i, 32'(usage[i]), 32'(sz));
         chk("clear_pending", i, 32'(pend[i]), 32'(ph[i] != 0));
         chk("clear_done", i, 32'(done[i]), 32'(ph[i] == 3));
         chk("clear_dropped", i, 32'(drop[i]), 32'((ph[i] == 3) && (sz != 0)));
         if (e_dval) chk("dst_data", i, 32'(ddata[i]), 32'(mq[i][0]));
         if (done[i] === 1'b1) act_done[i]++;
         if (ph[i] == 3) exp_done[i]++;
      end
      if (rst) begin
         mq[i].delete();
         ph[i]   = 0;
         tcnt[i] = 0;
      end else if (mval) begin
         do_push = src_valid && e_srdy;
         do_pop  = e_dval && dst_ready;
         if (do_pop)  void'(mq[i].pop_front());
         if (do_push) mq[i].push_back(src_data);
         case (ph[i])
            0: if (clear) ph[i] = 1;
            1: begin
               if (drn && mq[i].size() != 0) begin
                  ph[i]   = 2;
                  tcnt[i] = 0;
               end else ph[i] = 3;
            end
            2: begin
               if (mq[i].size() == 0 || tcnt[i] == TMO - 1) ph[i] = 3;
               else tcnt[i]++;
            end
            default: begin
               mq[i].delete();
               ph[i] = 0;
            end
         endcase
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) model_cycle(i);
      if (rst) mval = 1'b1;
   end

   task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
      src_valid = v;
      src_data  = d;
      dst_ready = r;
      clear     = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         ph[i] = 0; tcnt[i] = 0; exp_done[i] = 0; act_done[i] = 0;
      end
      rst = 1'b1;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      rst = 1'b0;
      // fill to full, one rejected offer, then empty in order and wrap the pointers
      step(1, 8'h0A, 0, 0); step(1, 8'h0B, 0, 0); step(1, 8'h0C, 0, 0); step(1, 8'h0D, 0, 0);
      repeat (3) step(0, 0, 1, 0);
      step(1, 8'h11, 0, 0); step(1, 8'h22, 0, 0);
      step(0, 0, 1, 0); step(0, 0, 1, 0);
      // streaming at usage 1
      step(1, 8'h30, 0, 0);
      for (int k = 0; k < 10; k++) step(1, 8'(8'h40 + k), 1, 0);
      step(0, 0, 1, 0);
      // clear with 2 stored, consumer stalled: discard vs drain timeout
      step(1, 8'h51, 0, 0); step(1, 8'h52, 0, 0);
      step(0, 0, 0, 1);
      repeat (8) step(0, 0, 0, 0);
      // clear with 3 stored and a willing consumer
      step(1, 8'h61, 0, 0); step(1, 8'h62, 0, 0); step(1, 8'h63, 0, 0);
      step(0, 0, 1, 1);
      repeat (6) step(0, 0, 1, 0);
      // reset while the draining instance sits in DRAIN
      step(1, 8'h71, 0, 0); step(1, 8'h72, 0, 0); step(1, 8'h73, 0, 0);
      step(0, 0, 0, 1); step(0, 0, 0, 0); step(0, 0, 0, 0);
      rst = 1'b1;
      step(0, 0, 0, 0);
      rst = 1'b0;
      step(0, 0, 0, 0); step(0, 0, 0, 0);
      // second clear request arriving during FLUSH / DRAIN
      step(1, 8'h81, 0, 0); step(1, 8'h82, 0, 0);
      step(0, 0, 0, 1); step(0, 0, 0, 0); step(0, 0, 0, 1);
      repeat (8) step(0, 0, 0, 0);
      // randomized traffic with occasional clears and resets
      for (int k = 0; k < 1500; k++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            rst = 1'b1;
            step(0, 0, 1'($urandom_range(0, 1)), 0);
            rst = 1'b0;
         end else if (r < 7) begin
            step(0, 0, 1'($urandom_range(0, 1)), 1);
         end else begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom),
                 1'($urandom_range(0, 2) != 0), 0);
         end
      end
      repeat (12) step(0, 0, 1, 0);
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) chk("done_pulses", i, 32'(act_done[i]), 32'(exp_done[i]));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
